// File: rtl/mem_image_loader_pkg.sv
// rtl/mem_image_loader_pkg.sv - shared types and encodings for the boot image loader
// Purpose: loader state enum and the mem_rw encodings shared with the CPU memory interface.
// Ports: none (package).
package mem_image_loader_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WRITE  = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERROR  = 2'd3
    } loader_state_e;

    localparam logic MEM_WRITE = 1'b0;
    localparam logic MEM_READ  = 1'b1;

endpackage

// File: rtl/mem_image_loader_mfc_watchdog.sv
// rtl/mem_image_loader_mfc_watchdog.sv - clear/enable cycle counter with terminal-count flag
// Purpose: counts consecutive enabled cycles; flags the cycle that completes TIMEOUT of them.
// Ports:
//   clk_i     - clock
//   resetn_i  - synchronous active-low reset
//   clear_i   - return the count to zero (has priority over enable_i)
//   enable_i  - count this cycle
//   expire_o  - high while enabled in the TIMEOUT-th consecutive enabled cycle
module mfc_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TERM_CNT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAT_CNT  = CW'(TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != SAT_CNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flag in the cycle whose end would make the count reach TIMEOUT, so the
    // owner can change state on that same edge.
    assign expire_o = enable_i & (count_q == TERM_CNT);

endmodule

// File: rtl/mem_image_loader.sv
// rtl/mem_image_loader.sv - byte-stream to RAM boot image loader holding the CPU until done
// Purpose: accepts image bytes on a valid/ready handshake and writes them to RAM from address 0
//          via the MFA/MFC handshake; releases the CPU once the image is complete.
// Ports:
//   Clk, Clr                     - clock, synchronous active-low reset
//   in_data/in_valid/in_last     - image byte stream; in_ready accepts
//   mem_addr/mem_data/mem_mfa    - RAM write request, mem_rw always write
//   mem_mfc                      - RAM completion
//   cpu_run                      - CPU release
//   byte_count                   - bytes committed to RAM
//   err                          - sticky MFC timeout
module mem_image_loader
    import mem_image_loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int MEM_DEPTH   = 256,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_mfa,
    output logic              mem_rw,
    input  logic              mem_mfc,
    output logic              cpu_run,
    output logic [ADDR_W:0]   byte_count,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(MEM_DEPTH);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        data_q, data_d;
    logic              last_q, last_d;
    logic              ready_q, ready_d;
    logic              mfa_q, mfa_d;
    logic              run_q, run_d;
    logic              err_q, err_d;

    logic              mfc_seen;
    logic              wd_expire;

    // MFC only counts while a request is actually outstanding.
    assign mfc_seen = mfa_q & mem_mfc;

    mfc_watchdog #(
        .TIMEOUT(MFC_TIMEOUT)
    ) u_mfc_watchdog (
        .clk_i    (Clk),
        .resetn_i (Clr),
        .clear_i  (state_q != ST_WRITE),
        .enable_i (mfa_q & ~mem_mfc),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        last_d  = last_q;

        case (state_q)
            ST_ACCEPT: begin
                if (in_valid) begin
                    data_d  = in_data;
                    last_d  = in_last;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mfc_seen) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    // Truncate at capacity: a full RAM ends the load cleanly.
                    if (last_q || ((cnt_q + 1'b1) == DEPTH_CNT)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end else if (wd_expire) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase

        // Outputs decoded from the next state so they are registered yet
        // change on the same edge as the state itself.
        ready_d = (state_d == ST_ACCEPT);
        mfa_d   = (state_d == ST_WRITE);
        run_d   = (state_d == ST_DONE);
        err_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state_q <= ST_ACCEPT;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            mfa_q   <= 1'b0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            mfa_q   <= mfa_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = ready_q;
    assign mem_addr   = ptr_q;
    assign mem_data   = data_q;
    assign mem_mfa    = mfa_q;
    assign mem_rw     = MEM_WRITE;
    assign cpu_run    = run_q;
    assign byte_count = cnt_q;
    assign err        = err_q;

endmodule
